// File: rtl/spi_cmd_pkg.sv
// spi_cmd_pkg: shared opcodes, command/status field positions and FSM states
// for spi_cmd_exec. No ports; imported with import spi_cmd_pkg::*.
package spi_cmd_pkg;

    localparam logic [7:0] OP_NOP   = 8'h00;
    localparam logic [7:0] OP_WRITE = 8'h01;
    localparam logic [7:0] OP_READ  = 8'h02;
    localparam logic [7:0] OP_FILL  = 8'h03;
    localparam logic [7:0] OP_CHECK = 8'h04;

    localparam int TAG_HI  = 63;
    localparam int TAG_LO  = 56;
    localparam int OP_HI   = 55;
    localparam int OP_LO   = 48;
    localparam int ADDR_HI = 47;
    localparam int ADDR_LO = 24;
    localparam int CNT_HI  = 23;
    localparam int CNT_LO  = 16;
    localparam int WD_HI   = 15;
    localparam int WD_LO   = 0;

    localparam int ST_TAG_HI = 63;
    localparam int ST_TAG_LO = 56;
    localparam int ST_BUSY   = 55;
    localparam int ST_TMO    = 54;
    localparam int ST_ERR_HI = 47;
    localparam int ST_ERR_LO = 32;
    localparam int ST_OP_HI  = 23;
    localparam int ST_OP_LO  = 16;
    localparam int ST_RD_HI  = 15;
    localparam int ST_RD_LO  = 0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    function automatic logic is_mem_op(input logic [7:0] op);
        return (op == OP_WRITE) || (op == OP_READ) ||
               (op == OP_FILL)  || (op == OP_CHECK);
    endfunction

    function automatic logic is_burst(input logic [7:0] op);
        return (op == OP_FILL) || (op == OP_CHECK);
    endfunction

endpackage

// File: rtl/spi_cmd_exec.sv
// spi_cmd_exec: runs tagged commands from the SPI peek word as memory
// word transfers and reports a registered status word.
// Ports: clk, rst (sync, active high), cmd_word in, status_word out,
//   mem_req/mem_we/mem_addr/mem_wdata out, mem_ack/mem_rdata in.
// Option: define SPI_CMD_EXEC_TIMEOUT_EN for a 1024-cycle WAIT timeout.
module spi_cmd_exec
    import spi_cmd_pkg::*;
#(
    parameter int CMD_BITS  = 64,
    parameter int ADDR_BITS = 24
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [CMD_BITS-1:0]  cmd_word,
    output logic [CMD_BITS-1:0]  status_word,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [ADDR_BITS-1:0] mem_addr,
    output logic [15:0]          mem_wdata,
    input  logic                 mem_ack,
    input  logic [15:0]          mem_rdata
);

    state_t state, state_n;

    logic [7:0]           cmd_tag;
    logic [7:0]           cmd_op;
    logic [7:0]           cmd_cnt;
    logic [ADDR_BITS-1:0] cmd_addr;
    logic [15:0]          cmd_wd;

    logic [7:0]           tag_q;
    logic [7:0]           op_q;
    logic [7:0]           cnt_q;
    logic [7:0]           idx_q;
    logic [7:0]           last_tag;
    logic [ADDR_BITS-1:0] addr_q;
    logic [15:0]          pat_q;
    logic [15:0]          err_cnt;
    logic [15:0]          rd_data;
    logic                 tmo_flag;
    logic                 tmo_hit;

    logic                 accept;
    logic                 ack_ok;
    logic                 last_word;

    logic [7:0]           st_tag;
    logic [7:0]           st_op;
    logic                 st_busy;
    logic                 st_tmo;
    logic [15:0]          st_err;
    logic [15:0]          st_rd;

    assign cmd_tag  = cmd_word[TAG_HI:TAG_LO];
    assign cmd_op   = cmd_word[OP_HI:OP_LO];
    assign cmd_addr = ADDR_BITS'(cmd_word[ADDR_HI:ADDR_LO]);
    assign cmd_cnt  = cmd_word[CNT_HI:CNT_LO];
    assign cmd_wd   = cmd_word[WD_HI:WD_LO];

    // Only a fresh, nonzero tag seen while idle starts a command; tag
    // edits while busy are simply not looked at.
    assign accept = (state == S_IDLE) && (cmd_tag != 8'h00) &&
                    (cmd_tag != last_tag);

    assign ack_ok    = (state == S_WAIT) && mem_req && mem_ack;
    assign last_word = is_burst(op_q) ? (idx_q == cnt_q) : 1'b1;

`ifdef SPI_CMD_EXEC_TIMEOUT_EN
    logic [9:0] tmo_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt <= '0;
        end else if (state == S_WAIT) begin
            tmo_cnt <= tmo_cnt + 10'd1;
        end else begin
            tmo_cnt <= '0;
        end
    end

    assign tmo_hit = (state == S_WAIT) && !mem_ack &&
                     (tmo_cnt == 10'h3FF);
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE: begin
                if (accept) begin
                    state_n = is_mem_op(cmd_op) ? S_ISSUE : S_DONE;
                end
            end
            S_ISSUE: state_n = S_WAIT;
            S_WAIT: begin
                if (ack_ok) begin
                    state_n = last_word ? S_DONE : S_ISSUE;
                end else if (tmo_hit) begin
                    state_n = S_DONE;
                end
            end
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tag_q     <= '0;
            op_q      <= '0;
            cnt_q     <= '0;
            idx_q     <= '0;
            addr_q    <= '0;
            pat_q     <= '0;
            last_tag  <= '0;
            err_cnt   <= '0;
            rd_data   <= '0;
            tmo_flag  <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            st_tag    <= '0;
            st_op     <= '0;
            st_busy   <= 1'b0;
            st_tmo    <= 1'b0;
            st_err    <= '0;
            st_rd     <= '0;
        end else begin
            if (accept) begin
                tag_q    <= cmd_tag;
                op_q     <= cmd_op;
                cnt_q    <= cmd_cnt;
                addr_q   <= cmd_addr;
                pat_q    <= cmd_wd;
                idx_q    <= '0;
                tmo_flag <= 1'b0;
                if (cmd_op == OP_CHECK) begin
                    err_cnt <= '0;
                end
            end

            // mem_wdata carries the running pattern on reads too, so
            // CHECK compares against the word it is waiting on.
            if (state == S_ISSUE) begin
                mem_req   <= 1'b1;
                mem_we    <= (op_q == OP_WRITE) || (op_q == OP_FILL);
                mem_addr  <= addr_q;
                mem_wdata <= pat_q;
            end

            if (ack_ok) begin
                mem_req <= 1'b0;
                idx_q   <= idx_q + 8'd1;
                addr_q  <= addr_q + ADDR_BITS'(1);
                pat_q   <= pat_q + 16'd1;
                if (!mem_we) begin
                    rd_data <= mem_rdata;
                end
                if ((op_q == OP_CHECK) && (mem_rdata != mem_wdata) &&
                    (err_cnt != 16'hFFFF)) begin
                    err_cnt <= err_cnt + 16'd1;
                end
            end

            if (tmo_hit) begin
                mem_req  <= 1'b0;
                tmo_flag <= 1'b1;
            end

            if (state == S_DONE) begin
                last_tag <= tag_q;
                st_tag   <= tag_q;
                st_op    <= op_q;
                st_tmo   <= tmo_flag;
                st_err   <= err_cnt;
                st_rd    <= rd_data;
            end

            st_busy <= (state_n != S_IDLE);
        end
    end

    always_comb begin
        status_word = '0;
        status_word[ST_TAG_HI:ST_TAG_LO] = st_tag;
        status_word[ST_BUSY]             = st_busy;
        status_word[ST_TMO]              = st_tmo;
        status_word[ST_ERR_HI:ST_ERR_LO] = st_err;
        status_word[ST_OP_HI:ST_OP_LO]   = st_op;
        status_word[ST_RD_HI:ST_RD_LO]   = st_rd;
    end

endmodule

// File: doc/spi_cmd_exec.md
SPI_CMD_EXEC -- requirements
Module: spi_cmd_exec

Interface
REQ-001 SHALL have parameter CMD_BITS, default 64, meaning width of command and status words (matches the SPI peek width).
REQ-002 SHALL have parameter ADDR_BITS, default 24, meaning memory word-address width.
REQ-003 SHALL have one clock and a synchronous, active-high reset.
REQ-004 clk  in  1  system clock; all logic on its rising edge.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 cmd_word  in  CMD_BITS  latest word shifted in by the SPI peek stage; may change on any cycle.
REQ-007 status_word  out  CMD_BITS  registered result word, fed back as the SPI peek data_in.
REQ-008 mem_req  out  1  memory request, held until acknowledged.
REQ-009 mem_we  out  1  1 = write, 0 = read; valid while mem_req.
REQ-010 mem_addr  out  ADDR_BITS  word address; valid while mem_req.
REQ-011 mem_wdata  out  16  write data; valid while mem_req.
REQ-012 mem_ack  in  1  one-cycle acknowledge; completes the request.
REQ-013 mem_rdata  in  16  read data; valid in the mem_ack cycle of a read.

Function
REQ-014 cmd_word fields SHALL be: [63:56] tag, [55:48] opcode, [47:24] addr, [23:16] count, [15:0] wdata.
REQ-015 Opcodes SHALL be 0x00 NOP, 0x01 WRITE, 0x02 READ, 0x03 FILL, 0x04 CHECK; any other opcode behaves as NOP.
REQ-016 A command SHALL be accepted only in IDLE, only when cmd_word tag != last_tag and tag != 0x00; on acceptance all fields are latched in the same cycle.
REQ-017 States SHALL be IDLE, ISSUE, WAIT, DONE. IDLE->ISSUE on acceptance of a memory opcode; IDLE->DONE on acceptance of a NOP; ISSUE->WAIT after one cycle with mem_req=1; WAIT->ISSUE on mem_ack when words remain; WAIT->DONE on mem_ack of the last word; DONE->IDLE after one cycle.
REQ-018 WRITE and READ SHALL transfer exactly one word; count is ignored.
REQ-019 FILL and CHECK SHALL transfer count+1 words (1..256): address addr+i, pattern wdata+i, each mod 2^16.
REQ-020 Address increment SHALL wrap modulo 2^ADDR_BITS.
REQ-021 CHECK SHALL increment err_cnt on each mem_rdata != expected pattern; err_cnt saturates at 0xFFFF.
REQ-022 mem_req SHALL stay asserted with stable mem_we, mem_addr and mem_wdata from ISSUE until the mem_ack cycle, and SHALL deassert in the cycle after mem_ack.
REQ-023 mem_ack when mem_req=0 SHALL be ignored.
REQ-024 status_word SHALL be [63:56] last_tag, [55] busy (state != IDLE), [54] timeout flag, [53:48] zero, [47:32] err_cnt, [31:24] zero, [23:16] last opcode, [15:0] last read data (READ) or last word read (CHECK).
REQ-025 In DONE: last_tag <= latched tag; status_word fields update; err_cnt clears at acceptance of each CHECK only.
REQ-026 Tag changes while busy SHALL be ignored; the newest cmd_word is evaluated on the first IDLE cycle after completion. Intermediate commands are dropped.

Reset
REQ-027 Reset SHALL force IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, last_tag=0x00, err_cnt=0, timeout=0, status_word=0.
REQ-028 Reset mid-transfer SHALL abort at once, without waiting for mem_ack.

Configuration
REQ-029 With SPI_CMD_EXEC_TIMEOUT_EN defined, a 10-bit counter SHALL run in WAIT. If 1024 cycles pass without mem_ack: mem_req drops, the timeout flag sets, and the state goes to DONE (remaining words skipped). The flag clears at the next acceptance.
REQ-030 Without SPI_CMD_EXEC_TIMEOUT_EN, WAIT SHALL persist until mem_ack, and status bit 54 SHALL read 0.

Structure
REQ-031 A shared package spi_cmd_pkg SHALL hold the opcode constants, the field bit positions, and the state enum typedef.
REQ-032 The design SHALL be a single module with no sub-module; the pattern/address generator is inline.

Verification
REQ-033 WRITE: cmd tag=0x01 op=0x01 addr=0x000010 wdata=0xBEEF, 2-cycle ack -> one mem_req with we=1, addr=0x10, wdata=0xBEEF; status tag=0x01, busy=0.
REQ-034 READ: memory returns 0x1234 for tag=0x02 op=0x02 -> status[15:0]=0x1234, status[23:16]=0x02.
REQ-035 CHECK: FILL count=3 wdata=0x0100 at addr=0xFFFFFE, then CHECK with one corrupted word -> addresses 0xFFFFFE, 0xFFFFFF, 0x000000, 0x000001; err_cnt=1.
REQ-036 Tag changes 0x05->0x06->0x07 during a busy FILL -> only 0x07 executes after completion; a repeated tag 0x07 or tag 0x00 is not executed.
REQ-037 Reset asserted in WAIT -> next cycle mem_req=0, status_word=0; tag=0x01 is then accepted again.
REQ-038 With SPI_CMD_EXEC_TIMEOUT_EN and mem_ack never asserted -> mem_req drops after 1024 cycles; status bit54=1, busy=0.
